// File: rtl/mbus_pwr_pkg.sv
// Shared types and constants for the MBus layer power sequencer.
package mbus_pwr_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_PWR,
        ST_W_CLK,
        ST_W_RST,
        ST_W_ISO,
        ST_S_ISO,
        ST_S_RST,
        ST_S_CLK,
        ST_S_PWR
    } state_t;

    localparam logic HELD = 1'b1;
    localparam logic REL  = 1'b0;

    // Domain index width, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mbus_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or above the pointer, wrapping.
module mbus_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt_oh,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_vld
);

    int unsigned w_idx;

    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        w_idx     = 0;
        for (int unsigned off = 0; off < N; off++) begin
            w_idx = (32'(i_ptr) + off) % N;
            if (!o_gnt_vld && i_req[IDX_W'(w_idx)]) begin
                o_gnt_vld                  = 1'b1;
                o_gnt_idx                  = IDX_W'(w_idx);
                o_gnt_oh[IDX_W'(w_idx)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mbus_layer_power_seq.sv
// Shared wake/sleep sequencer for NUM_DOMAINS MBus layer power domains, one domain at a time.
module mbus_layer_power_seq
    import mbus_pwr_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned IDX_W       = idx_w(NUM_DOMAINS)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NUM_DOMAINS-1:0] WAKE_REQ,
    input  logic [NUM_DOMAINS-1:0] SLEEP_REQ,
    output logic [NUM_DOMAINS-1:0] LC_POWER_ON,
    output logic [NUM_DOMAINS-1:0] LC_RELEASE_CLK,
    output logic [NUM_DOMAINS-1:0] LC_RELEASE_RST,
    output logic [NUM_DOMAINS-1:0] LC_RELEASE_ISO,
    output logic [NUM_DOMAINS-1:0] DOMAIN_ACTIVE,
    output logic                   BUSY,
    output logic [IDX_W-1:0]       CUR_DOMAIN
);

    localparam int unsigned CNT_W = $clog2(STEP_CYCLES + 1);

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]       r_cur, w_cur_nxt, r_ptr, w_ptr_nxt;
    logic [NUM_DOMAINS-1:0] r_wake_pend, w_wake_pend_nxt, r_sleep_pend, w_sleep_pend_nxt;
    logic [NUM_DOMAINS-1:0] r_pwr, r_clk, r_rst, r_iso, r_active;
    logic [NUM_DOMAINS-1:0] w_pwr_nxt, w_clk_nxt, w_rst_nxt, w_iso_nxt, w_active_nxt;
    logic                   r_busy;

    logic [NUM_DOMAINS-1:0] w_gnt_oh, w_gnt_clr, w_waking_oh, w_up;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic                   w_gnt_vld, w_gnt_wake, w_grant, w_step_done;

    mbus_rr_arbiter #(
        .N     (NUM_DOMAINS),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req     (r_wake_pend | r_sleep_pend),
        .i_ptr     (r_ptr),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    assign w_gnt_wake  = |(r_wake_pend & w_gnt_oh);
    assign w_step_done = (r_cnt == CNT_W'(STEP_CYCLES - 1));

    // Sequencer next state and next output levels.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_cur_nxt    = r_cur;
        w_ptr_nxt    = r_ptr;
        w_pwr_nxt    = r_pwr;
        w_clk_nxt    = r_clk;
        w_rst_nxt    = r_rst;
        w_iso_nxt    = r_iso;
        w_active_nxt = r_active;
        w_grant      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_gnt_vld) begin
                    w_grant   = 1'b1;
                    w_cur_nxt = w_gnt_idx;
                    w_ptr_nxt = (w_gnt_idx == IDX_W'(NUM_DOMAINS - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
                    if (w_gnt_wake) begin
                        w_state_nxt          = ST_W_PWR;
                        w_pwr_nxt[w_gnt_idx] = REL;
                    end else begin
                        w_state_nxt             = ST_S_ISO;
                        w_iso_nxt[w_gnt_idx]    = HELD;
                        w_active_nxt[w_gnt_idx] = 1'b0;
                    end
                end
            end
            ST_W_PWR: if (w_step_done) begin
                w_state_nxt      = ST_W_CLK;
                w_clk_nxt[r_cur] = REL;
                w_cnt_nxt        = '0;
            end
            ST_W_CLK: if (w_step_done) begin
                w_state_nxt      = ST_W_RST;
                w_rst_nxt[r_cur] = REL;
                w_cnt_nxt        = '0;
            end
            ST_W_RST: if (w_step_done) begin
                w_state_nxt         = ST_W_ISO;
                w_iso_nxt[r_cur]    = REL;
                w_active_nxt[r_cur] = 1'b1;
                w_cnt_nxt           = '0;
            end
            ST_S_ISO: if (w_step_done) begin
                w_state_nxt      = ST_S_RST;
                w_rst_nxt[r_cur] = HELD;
                w_cnt_nxt        = '0;
            end
            ST_S_RST: if (w_step_done) begin
                w_state_nxt      = ST_S_CLK;
                w_clk_nxt[r_cur] = HELD;
                w_cnt_nxt        = '0;
            end
            ST_S_CLK: if (w_step_done) begin
                w_state_nxt      = ST_S_PWR;
                w_pwr_nxt[r_cur] = HELD;
                w_cnt_nxt        = '0;
            end
            ST_W_ISO, ST_S_PWR: if (w_step_done) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A domain counts as "up" once a wake is granted and until a sleep is granted.
    always_comb begin
        w_gnt_clr   = w_grant ? w_gnt_oh : '0;
        w_waking_oh = '0;
        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
            w_waking_oh[i] = (r_state inside {ST_W_PWR, ST_W_CLK, ST_W_RST, ST_W_ISO})
                             && (r_cur == IDX_W'(i));
        end
        w_up = (r_active & ~(w_gnt_clr & ~{NUM_DOMAINS{w_gnt_wake}}))
             | (w_gnt_clr & {NUM_DOMAINS{w_gnt_wake}})
             | w_waking_oh;
        w_wake_pend_nxt  = (r_wake_pend  & ~w_gnt_clr) | (WAKE_REQ  & ~w_up);
        w_sleep_pend_nxt = (r_sleep_pend & ~w_gnt_clr) | (SLEEP_REQ &  w_up);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_cur        <= '0;
            r_ptr        <= '0;
            r_wake_pend  <= '0;
            r_sleep_pend <= '0;
            r_pwr        <= '1;
            r_clk        <= '1;
            r_rst        <= '1;
            r_iso        <= '1;
            r_active     <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cur        <= w_cur_nxt;
            r_ptr        <= w_ptr_nxt;
            r_wake_pend  <= w_wake_pend_nxt;
            r_sleep_pend <= w_sleep_pend_nxt;
            r_pwr        <= w_pwr_nxt;
            r_clk        <= w_clk_nxt;
            r_rst        <= w_rst_nxt;
            r_iso        <= w_iso_nxt;
            r_active     <= w_active_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign LC_POWER_ON    = r_pwr;
    assign LC_RELEASE_CLK = r_clk;
    assign LC_RELEASE_RST = r_rst;
    assign LC_RELEASE_ISO = r_iso;
    assign DOMAIN_ACTIVE  = r_active;
    assign BUSY           = r_busy;
    assign CUR_DOMAIN     = r_cur;

`ifndef SYNTHESIS
    logic [NUM_DOMAINS-1:0] w_mid;
    assign w_mid = ~((r_pwr & r_clk & r_rst & r_iso) | ~(r_pwr | r_clk | r_rst | r_iso));

    a_release_order: assert property (@(posedge CLK) disable iff (RESET)
        ((~r_iso & r_rst) | (~r_rst & r_clk) | (~r_clk & r_pwr)) == '0);
    a_one_in_flight: assert property (@(posedge CLK) disable iff (RESET) $onehot0(w_mid));
`endif

endmodule

// File: tb/tb_mbus_layer_power_seq.sv
// Scoreboard bench: stimulus queues expected output snapshots, a monitor pops one per output change.
module tb_mbus_layer_power_seq;

    localparam int S = 4;

    typedef struct packed {
        logic [3:0] pwr;
        logic [3:0] clk;
        logic [3:0] rst;
        logic [3:0] iso;
        logic [3:0] act;
        logic       busy;
        logic [1:0] cur;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t s;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] WAKE_REQ = 4'b0;
    logic [3:0] SLEEP_REQ = 4'b0;
    logic [3:0] LC_POWER_ON, LC_RELEASE_CLK, LC_RELEASE_RST, LC_RELEASE_ISO, DOMAIN_ACTIVE;
    logic       BUSY;
    logic [1:0] CUR_DOMAIN;

    exp_t  q[$];
    snap_t m;
    int    cyc = 0;
    bit    done = 1'b0;
    int    checks = 0;
    int    failures = 0;

    mbus_layer_power_seq #(
        .NUM_DOMAINS (4),
        .STEP_CYCLES (S)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .WAKE_REQ       (WAKE_REQ),
        .SLEEP_REQ      (SLEEP_REQ),
        .LC_POWER_ON    (LC_POWER_ON),
        .LC_RELEASE_CLK (LC_RELEASE_CLK),
        .LC_RELEASE_RST (LC_RELEASE_RST),
        .LC_RELEASE_ISO (LC_RELEASE_ISO),
        .DOMAIN_ACTIVE  (DOMAIN_ACTIVE),
        .BUSY           (BUSY),
        .CUR_DOMAIN     (CUR_DOMAIN)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic snap_t rst_snap();
        snap_t r;
        r.pwr = 4'hF; r.clk = 4'hF; r.rst = 4'hF; r.iso = 4'hF;
        r.act = 4'h0; r.busy = 1'b0; r.cur = 2'd0;
        return r;
    endfunction

    function automatic snap_t get_snap();
        snap_t r;
        r.pwr = LC_POWER_ON; r.clk = LC_RELEASE_CLK; r.rst = LC_RELEASE_RST;
        r.iso = LC_RELEASE_ISO; r.act = DOMAIN_ACTIVE; r.busy = BUSY; r.cur = CUR_DOMAIN;
        return r;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("pwr=%h clk=%h rst=%h iso=%h act=%h busy=%b cur=%0d",
                         s.pwr, s.clk, s.rst, s.iso, s.act, s.busy, s.cur);
    endfunction

    task automatic push(input int c);
        exp_t e;
        e.cyc = c;
        e.s   = m;
        q.push_back(e);
    endtask

    // Expected wake of domain d granted at edge g; n limits how many steps are reached.
    task automatic exp_wake(input int g, input int d, input int n);
        m.pwr[d] = 1'b0; m.busy = 1'b1; m.cur = 2'(d); push(g);
        if (n > 1) begin m.clk[d] = 1'b0; push(g + S); end
        if (n > 2) begin m.rst[d] = 1'b0; push(g + 2*S); end
        if (n > 3) begin m.iso[d] = 1'b0; m.act[d] = 1'b1; push(g + 3*S); end
        if (n > 4) begin m.busy = 1'b0; push(g + 4*S); end
    endtask

    task automatic exp_sleep(input int g, input int d);
        m.iso[d] = 1'b1; m.act[d] = 1'b0; m.busy = 1'b1; m.cur = 2'(d); push(g);
        m.rst[d] = 1'b1; push(g + S);
        m.clk[d] = 1'b1; push(g + 2*S);
        m.pwr[d] = 1'b1; push(g + 3*S);
        m.busy = 1'b0; push(g + 4*S);
    endtask

    task automatic exp_reset(input int c);
        m = rst_snap();
        push(c);
    endtask

    // Present requests so that they are sampled at edge k.
    task automatic pulse(input int k, input logic [3:0] w, input logic [3:0] s);
        while (cyc < k - 1) @(negedge CLK);
        WAKE_REQ  = w;
        SLEEP_REQ = s;
        @(negedge CLK);
        WAKE_REQ  = 4'b0;
        SLEEP_REQ = 4'b0;
    endtask

    task automatic rst_at(input int k);
        while (cyc < k - 1) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Stimulus
    initial begin
        m = rst_snap();
        while (cyc < 3) @(negedge CLK);
        RESET = 1'b0;

        exp_wake(11, 1, 5);
        pulse(10, 4'b0010, 4'b0000);

        pulse(30, 4'b0010, 4'b0000);
        pulse(31, 4'b0000, 4'b0001);

        exp_wake(36, 2, 5);
        pulse(35, 4'b0100, 4'b0000);
        exp_sleep(56, 2);
        pulse(55, 4'b0000, 4'b0100);

        exp_wake(76, 0, 5);
        pulse(75, 4'b0001, 4'b0001);

        exp_wake(96, 3, 5);
        exp_sleep(113, 3);
        pulse(95, 4'b1000, 4'b0000);
        pulse(100, 4'b0000, 4'b1000);

        exp_reset(135);
        rst_at(135);
        exp_wake(141, 0, 5);
        exp_wake(158, 1, 5);
        exp_wake(175, 3, 5);
        pulse(140, 4'b1011, 4'b0000);

        exp_reset(194);
        rst_at(194);
        exp_wake(201, 1, 3);
        exp_reset(211);
        pulse(200, 4'b0010, 4'b0000);
        pulse(203, 4'b0100, 4'b0000);
        rst_at(211);

        while (cyc < 240) @(negedge CLK);
        done = 1'b1;
    end

    // Monitor and scoreboard
    initial begin
        snap_t prev;
        snap_t cur;
        exp_t  e;
        while (cyc < 3) @(negedge CLK);
        cur = get_snap();
        checks++;
        if (cur !== rst_snap()) begin
            failures++;
            $display("FAIL reset_state got %s want %s", fmt(cur), fmt(rst_snap()));
        end
        prev = cur;
        while (!done && cyc < 2000) begin
            @(negedge CLK);
            cur = get_snap();
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got %s", cyc, fmt(cur));
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || cur !== e.s) begin
                        failures++;
                        $display("FAIL event cyc=%0d got %s want cyc=%0d %s",
                                 cyc, fmt(cur), e.cyc, fmt(e.s));
                    end
                end
                prev = cur;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL timeout cyc=%0d", cyc);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL missing_events remaining=%0d next_cyc=%0d", q.size(), q[0].cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
